// File: rtl/axi4_lite_addr_map_package.sv
// Shared AXI4-Lite interconnect package.
// Holds bus widths, the number of masters sharing the interconnect, the
// arbiter state encoding and the AXI response codes.
package axi4_lite_addr_map_package;

    localparam int unsigned ADDR_WIDTH = 32;
    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned MASTER_NUM = 2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_RESP
    } arb_state_t;

endpackage

// File: rtl/axi4_lite_rr_picker.sv
// Combinational round-robin selector.
// Ports:
//   req_i   - request vector, one bit per master
//   ptr_i   - index with highest priority this round
//   found_o - at least one request is pending
//   idx_o   - first requester at or after ptr_i, wrapping modulo N
module axi4_lite_rr_picker #(
    parameter int unsigned N = 2
) (
    input  logic [N-1:0]         req_i,
    input  logic [$clog2(N)-1:0] ptr_i,
    output logic                 found_o,
    output logic [$clog2(N)-1:0] idx_o
);

    localparam int unsigned IdxW = $clog2(N);

    int unsigned cand;

    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        cand    = 0;
        for (int unsigned i = 0; i < N; i++) begin
            cand = (32'(ptr_i) + i) % N;
            if (!found_o && req_i[cand[IdxW-1:0]]) begin
                found_o = 1'b1;
                idx_o   = cand[IdxW-1:0];
            end
        end
    end

endmodule

// File: rtl/axi4_lite_master_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite master port between MASTER_NUM
// requesters. One read or write is in flight at a time; the grant is held
// from arbitration until the response handshake completes.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   m_aw*/m_w*/m_b*     - per-master write channels
//   m_ar*/m_r*          - per-master read channels
//   s_*                 - shared downstream port to the interconnect
//   grant_idx           - currently granted master
//   busy                - a transaction is in progress
module axi4_lite_master_arbiter #(
    parameter int unsigned MASTER_NUM = axi4_lite_addr_map_package::MASTER_NUM,
    parameter int unsigned ADDR_WIDTH = axi4_lite_addr_map_package::ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = axi4_lite_addr_map_package::DATA_WIDTH
) (
    input  logic                                     clk,
    input  logic                                     rst,
    // Per-master side
    input  logic [MASTER_NUM-1:0][ADDR_WIDTH-1:0]    m_awaddr,
    input  logic [MASTER_NUM-1:0]                    m_awvalid,
    output logic [MASTER_NUM-1:0]                    m_awready,
    input  logic [MASTER_NUM-1:0][DATA_WIDTH-1:0]    m_wdata,
    input  logic [MASTER_NUM-1:0][DATA_WIDTH/8-1:0]  m_wstrb,
    input  logic [MASTER_NUM-1:0]                    m_wvalid,
    output logic [MASTER_NUM-1:0]                    m_wready,
    output logic [MASTER_NUM-1:0][1:0]               m_bresp,
    output logic [MASTER_NUM-1:0]                    m_bvalid,
    input  logic [MASTER_NUM-1:0]                    m_bready,
    input  logic [MASTER_NUM-1:0][ADDR_WIDTH-1:0]    m_araddr,
    input  logic [MASTER_NUM-1:0]                    m_arvalid,
    output logic [MASTER_NUM-1:0]                    m_arready,
    output logic [MASTER_NUM-1:0][DATA_WIDTH-1:0]    m_rdata,
    output logic [MASTER_NUM-1:0][1:0]               m_rresp,
    output logic [MASTER_NUM-1:0]                    m_rvalid,
    input  logic [MASTER_NUM-1:0]                    m_rready,
    // Shared downstream side
    output logic [ADDR_WIDTH-1:0]                    s_awaddr,
    output logic                                     s_awvalid,
    input  logic                                     s_awready,
    output logic [DATA_WIDTH-1:0]                    s_wdata,
    output logic [DATA_WIDTH/8-1:0]                  s_wstrb,
    output logic                                     s_wvalid,
    input  logic                                     s_wready,
    input  logic [1:0]                               s_bresp,
    input  logic                                     s_bvalid,
    output logic                                     s_bready,
    output logic [ADDR_WIDTH-1:0]                    s_araddr,
    output logic                                     s_arvalid,
    input  logic                                     s_arready,
    input  logic [DATA_WIDTH-1:0]                    s_rdata,
    input  logic [1:0]                               s_rresp,
    input  logic                                     s_rvalid,
    output logic                                     s_rready,
    // Status
    output logic [$clog2(MASTER_NUM)-1:0]            grant_idx,
    output logic                                     busy
);

    import axi4_lite_addr_map_package::*;

    localparam int unsigned IdxW = $clog2(MASTER_NUM);

    arb_state_t      state_q;
    logic [IdxW-1:0] grant_q;
    logic [IdxW-1:0] ptr_q;
    logic [IdxW-1:0] ptr_next;
    logic            aw_done_q, aw_done_d;
    logic            w_done_q, w_done_d;
    logic            pick_found;
    logic [IdxW-1:0] pick_idx;

    // Only address valids count as requests; a lone W is not a request.
    axi4_lite_rr_picker #(
        .N (MASTER_NUM)
    ) u_picker (
        .req_i   (m_awvalid | m_arvalid),
        .ptr_i   (ptr_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    assign ptr_next  = (grant_q == IdxW'(MASTER_NUM - 1)) ? '0 : grant_q + 1'b1;
    assign aw_done_d = aw_done_q | (s_awvalid & s_awready);
    assign w_done_d  = w_done_q  | (s_wvalid  & s_wready);
    assign grant_idx = grant_q;
    assign busy      = (state_q != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            ptr_q     <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_found) begin
                        grant_q <= pick_idx;
                        // Write wins when the winner asserts both AW and AR.
                        state_q <= m_awvalid[pick_idx] ? WR_REQ : RD_REQ;
                    end
                end
                WR_REQ: begin
                    aw_done_q <= aw_done_d;
                    w_done_q  <= w_done_d;
                    if (aw_done_d && w_done_d) begin
                        state_q <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (s_bvalid && m_bready[grant_q]) begin
                        state_q   <= IDLE;
                        ptr_q     <= ptr_next;
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                    end
                end
                RD_REQ: begin
                    if (s_arvalid && s_arready) begin
                        state_q <= RD_RESP;
                    end
                end
                RD_RESP: begin
                    if (s_rvalid && m_rready[grant_q]) begin
                        state_q <= IDLE;
                        ptr_q   <= ptr_next;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Routing is purely combinational from the registered grant and state.
    always_comb begin
        m_awready = '0;
        m_wready  = '0;
        m_bresp   = '0;
        m_bvalid  = '0;
        m_arready = '0;
        m_rdata   = '0;
        m_rresp   = '0;
        m_rvalid  = '0;
        s_awaddr  = '0;
        s_awvalid = 1'b0;
        s_wdata   = '0;
        s_wstrb   = '0;
        s_wvalid  = 1'b0;
        s_bready  = 1'b0;
        s_araddr  = '0;
        s_arvalid = 1'b0;
        s_rready  = 1'b0;
        case (state_q)
            WR_REQ: begin
                s_awaddr           = m_awaddr[grant_q];
                s_awvalid          = m_awvalid[grant_q] & ~aw_done_q;
                m_awready[grant_q] = s_awready & ~aw_done_q;
                s_wdata            = m_wdata[grant_q];
                s_wstrb            = m_wstrb[grant_q];
                s_wvalid           = m_wvalid[grant_q] & ~w_done_q;
                m_wready[grant_q]  = s_wready & ~w_done_q;
            end
            WR_RESP: begin
                m_bvalid[grant_q] = s_bvalid;
                m_bresp[grant_q]  = s_bresp;
                s_bready          = m_bready[grant_q];
            end
            RD_REQ: begin
                s_araddr           = m_araddr[grant_q];
                s_arvalid          = m_arvalid[grant_q];
                m_arready[grant_q] = s_arready;
            end
            RD_RESP: begin
                m_rvalid[grant_q] = s_rvalid;
                m_rdata[grant_q]  = s_rdata;
                m_rresp[grant_q]  = s_rresp;
                s_rready          = m_rready[grant_q];
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_axi4_lite_master_arbiter.sv
// Directed bench for axi4_lite_master_arbiter with a queue of expected
// grants and response values.
module tb_axi4_lite_master_arbiter;

    import axi4_lite_addr_map_package::*;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst;

    logic [N-1:0][AW-1:0]   m_awaddr, m_araddr;
    logic [N-1:0][DW-1:0]   m_wdata, m_rdata;
    logic [N-1:0][DW/8-1:0] m_wstrb;
    logic [N-1:0][1:0]      m_bresp, m_rresp;
    logic [N-1:0] m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic [N-1:0] m_arvalid, m_arready, m_rvalid, m_rready;

    logic [AW-1:0]   s_awaddr, s_araddr;
    logic [DW-1:0]   s_wdata, s_rdata;
    logic [DW/8-1:0] s_wstrb;
    logic [1:0]      s_bresp, s_rresp;
    logic s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
    logic s_arvalid, s_arready, s_rvalid, s_rready;

    logic [0:0] grant_idx;
    logic       busy;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    logic [63:0] exp_q[$];

    axi4_lite_master_arbiter #(
        .MASTER_NUM (N),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .m_awaddr  (m_awaddr),
        .m_awvalid (m_awvalid),
        .m_awready (m_awready),
        .m_wdata   (m_wdata),
        .m_wstrb   (m_wstrb),
        .m_wvalid  (m_wvalid),
        .m_wready  (m_wready),
        .m_bresp   (m_bresp),
        .m_bvalid  (m_bvalid),
        .m_bready  (m_bready),
        .m_araddr  (m_araddr),
        .m_arvalid (m_arvalid),
        .m_arready (m_arready),
        .m_rdata   (m_rdata),
        .m_rresp   (m_rresp),
        .m_rvalid  (m_rvalid),
        .m_rready  (m_rready),
        .s_awaddr  (s_awaddr),
        .s_awvalid (s_awvalid),
        .s_awready (s_awready),
        .s_wdata   (s_wdata),
        .s_wstrb   (s_wstrb),
        .s_wvalid  (s_wvalid),
        .s_wready  (s_wready),
        .s_bresp   (s_bresp),
        .s_bvalid  (s_bvalid),
        .s_bready  (s_bready),
        .s_araddr  (s_araddr),
        .s_arvalid (s_arvalid),
        .s_arready (s_arready),
        .s_rdata   (s_rdata),
        .s_rresp   (s_rresp),
        .s_rvalid  (s_rvalid),
        .s_rready  (s_rready),
        .grant_idx (grant_idx),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish, required finish before 100000");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic sb_check(input string tag, input logic [63:0] obs);
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $error("FAIL %s: observed 0x%0h required a queued entry (queue empty)", tag, obs);
        end else begin
            chk(tag, obs, exp_q.pop_front());
        end
    endtask

    initial begin
        int e;
        rst       = 1'b1;
        m_awaddr  = '0; m_awvalid = '0; m_wdata  = '0; m_wstrb  = '0; m_wvalid = '0;
        m_bready  = '0; m_araddr  = '0; m_arvalid = '0; m_rready = '0;
        s_awready = 1'b0; s_wready = 1'b0; s_bresp = '0; s_bvalid = 1'b0;
        s_arready = 1'b0; s_rdata  = '0;   s_rresp = '0; s_rvalid = 1'b0;
        repeat (2) tick();

        // Reset state
        chk("rst_busy", 64'(busy), 0);
        chk("rst_grant", 64'(grant_idx), 0);
        chk("rst_s_ctl", 64'({s_awvalid, s_wvalid, s_arvalid, s_bready, s_rready}), 0);
        chk("rst_m_ctl", 64'({m_awready, m_wready, m_arready, m_bvalid, m_rvalid}), 0);
        chk("rst_s_data", 64'({s_awaddr, s_wdata}), 0);
        rst = 1'b0;

        // M0 single write, OKAY response
        m_awaddr[0] = 32'h0000_0100; m_awvalid[0] = 1'b1;
        m_wdata[0]  = 32'hDEAD_BEEF; m_wstrb[0]   = 4'hF; m_wvalid[0] = 1'b1;
        m_bready    = 2'b11; s_awready = 1'b1; s_wready = 1'b1;
        #1;
        chk("t1_idle_no_fwd", 64'(s_awvalid), 0);
        tick();
        chk("t1_busy", 64'(busy), 1);
        chk("t1_grant", 64'(grant_idx), 0);
        chk("t1_awaddr", 64'(s_awaddr), 64'h100);
        chk("t1_wdata", 64'(s_wdata), 64'hDEAD_BEEF);
        chk("t1_wstrb", 64'(s_wstrb), 64'hF);
        chk("t1_m0_ready", 64'({m_awready[0], m_wready[0]}), 64'b11);
        chk("t1_m1_ready", 64'({m_awready[1], m_wready[1]}), 0);
        tick();
        m_awvalid[0] = 1'b0; m_wvalid[0] = 1'b0;
        exp_q.push_back(64'(RESP_OKAY));
        s_bvalid = 1'b1; s_bresp = RESP_OKAY;
        #1;
        chk("t1_m1_ready_b", 64'({m_awready[1], m_wready[1]}), 0);
        chk("t1_bvalid", 64'(m_bvalid), 64'b01);
        sb_check("t1_bresp", 64'(m_bresp[0]));
        tick();
        s_bvalid = 1'b0;
        #1;
        chk("t1_busy_fall", 64'(busy), 0);

        // Simultaneous reads alternate 0,1,0,1 after reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_araddr[0] = 32'h0000_1000; m_araddr[1] = 32'h0000_1000;
        m_arvalid = 2'b11; m_rready = 2'b11; s_arready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            e = k % 2;
            exp_q.push_back(64'(e));
            for (int i = 0; i < 8 && s_arvalid !== 1'b1; i++) tick();
            chk("t2_arvalid", 64'(s_arvalid), 1);
            sb_check("t2_grant", 64'(grant_idx));
            chk("t2_araddr", 64'(s_araddr), 64'h1000);
            tick();
            s_rvalid = 1'b1; s_rdata = 32'hA000_0000 + 32'(k); s_rresp = RESP_OKAY;
            exp_q.push_back(64'(32'hA000_0000 + 32'(k)));
            #1;
            chk("t2_rvalid_route", 64'(m_rvalid), 64'd1 << e);
            sb_check("t2_rdata", 64'(m_rdata[e]));
            chk("t2_rdata_other", 64'(m_rdata[1-e]), 0);
            tick();
            s_rvalid = 1'b0;
        end
        m_arvalid = 2'b00;

        // M1 presents W two cycles before AW
        m_wdata[1] = 32'h1234_5678; m_wstrb[1] = 4'h3; m_wvalid[1] = 1'b1;
        m_awaddr[1] = 32'h0000_0200; s_awready = 1'b0; s_wready = 1'b1;
        tick();
        tick();
        chk("t3_w_only_idle", 64'(busy), 0);
        chk("t3_w_only_no_fwd", 64'(s_wvalid), 0);
        m_awvalid[1] = 1'b1;
        tick();
        chk("t3_grant", 64'(grant_idx), 1);
        chk("t3_wvalid", 64'(s_wvalid), 1);
        chk("t3_wdata", 64'(s_wdata), 64'h1234_5678);
        chk("t3_wready", 64'(m_wready), 64'b10);
        chk("t3_awready_low", 64'(m_awready), 0);
        tick();
        m_wvalid[1] = 1'b0; s_bvalid = 1'b1; s_bresp = RESP_SLVERR;
        #1;
        chk("t3_still_req", 64'({busy, s_awvalid, s_wvalid}), 64'b110);
        chk("t3_no_b_early", 64'({s_bready, m_bvalid}), 0);
        s_awready = 1'b1;
        #1;
        chk("t3_awready", 64'(m_awready), 64'b10);
        tick();
        m_awvalid[1] = 1'b0;
        exp_q.push_back(64'(RESP_SLVERR));
        #1;
        chk("t3_aw_low", 64'(s_awvalid), 0);
        chk("t3_bvalid", 64'(m_bvalid), 64'b10);
        sb_check("t3_bresp", 64'(m_bresp[1]));
        chk("t3_bready", 64'(s_bready), 1);
        tick();
        s_bvalid = 1'b0; s_bresp = '0;
        #1;
        chk("t3_idle", 64'(busy), 0);

        // Slow R on M0 while M1 waits
        m_araddr[0] = 32'h0000_2000; m_arvalid[0] = 1'b1; s_arready = 1'b1;
        tick();
        chk("t4_grant0", 64'(grant_idx), 0);
        tick();
        m_arvalid[0] = 1'b0; m_araddr[1] = 32'h0000_3000; m_arvalid[1] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t4_hold_grant", 64'(grant_idx), 0);
            chk("t4_m1_quiet", 64'({m_arready[1], m_rvalid[1]}), 0);
            chk("t4_no_ar", 64'(s_arvalid), 0);
            tick();
        end
        s_rvalid = 1'b1; s_rdata = 32'hCAFE_0000;
        exp_q.push_back(64'h0000_0000_CAFE_0000);
        #1;
        sb_check("t4_rdata", 64'(m_rdata[0]));
        chk("t4_rvalid", 64'(m_rvalid), 64'b01);
        tick();
        s_rvalid = 1'b0;
        tick();
        chk("t4_grant1", 64'(grant_idx), 1);
        chk("t4_araddr1", 64'(s_araddr), 64'h3000);
        tick();
        m_arvalid[1] = 1'b0;
        #1;
        chk("t4_in_rresp", 64'(s_rready), 1);

        // Reset while in RD_RESP
        rst = 1'b1;
        tick();
        chk("t5_busy", 64'(busy), 0);
        chk("t5_grant", 64'(grant_idx), 0);
        chk("t5_s_ctl", 64'({s_awvalid, s_wvalid, s_arvalid, s_bready, s_rready}), 0);
        chk("t5_m_ctl", 64'({m_awready, m_wready, m_arready, m_bvalid, m_rvalid}), 0);
        s_rvalid = 1'b1;
        #1;
        chk("t5_r_blocked", 64'(m_rvalid), 0);
        s_rvalid = 1'b0;
        rst = 1'b0;
        m_arvalid = 2'b11;
        tick();
        chk("t5_ptr_reset", 64'(grant_idx), 0);
        tick();
        m_arvalid = 2'b00; s_rvalid = 1'b1;
        tick();
        s_rvalid = 1'b0;

        // M0 asserts AW and AR together; M1 joins while busy
        m_awaddr[0] = 32'h0000_0400; m_awvalid[0] = 1'b1;
        m_wdata[0]  = 32'h0000_55AA; m_wvalid[0]  = 1'b1;
        m_araddr[0] = 32'h0000_0500; m_arvalid[0] = 1'b1;
        s_awready = 1'b1; s_wready = 1'b1;
        tick();
        chk("t6_write_first", 64'({s_awvalid, s_arvalid}), 64'b10);
        chk("t6_grant0", 64'(grant_idx), 0);
        m_araddr[1] = 32'h0000_0600; m_arvalid[1] = 1'b1;
        tick();
        m_awvalid[0] = 1'b0; m_wvalid[0] = 1'b0; s_bvalid = 1'b1;
        tick();
        s_bvalid = 1'b0;
        tick();
        chk("t6_m1_next", 64'(grant_idx), 1);
        chk("t6_araddr1", 64'(s_araddr), 64'h600);
        tick();
        m_arvalid[1] = 1'b0; s_rvalid = 1'b1;
        tick();
        s_rvalid = 1'b0;
        tick();
        chk("t6_m0_read", 64'(grant_idx), 0);
        chk("t6_araddr0", 64'(s_araddr), 64'h500);
        tick();
        m_arvalid[0] = 1'b0; s_rvalid = 1'b1;
        tick();
        s_rvalid = 1'b0;
        #1;
        chk("t6_idle", 64'(busy), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/axi4_lite_master_arbiter.md
# axi4_lite_master_arbiter

Round-robin arbiter that shares the single AXI4-Lite master port of the interconnect (the port feeding the address decoder and slave mux) between MASTER_NUM requesters, e.g. the RV32IM instruction-fetch and data-memory AXI4-Lite masters. One transaction is in flight at a time, either a read or a write. The grant is held from arbitration until the response handshake completes, so the downstream decoder only ever sees one master.

## Interface
Parameters:
- MASTER_NUM, 2, number of requesting masters (≥2)
- ADDR_WIDTH, 32, from the shared package
- DATA_WIDTH, 32, from the shared package

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- m_awaddr/m_awvalid/m_awready  in/in/out  [MASTER_NUM][ADDR_WIDTH] / [MASTER_NUM] / [MASTER_NUM]  write address per master
- m_wdata/m_wstrb/m_wvalid/m_wready  in/in/in/out  [MASTER_NUM][DATA_WIDTH] / [MASTER_NUM][DATA_WIDTH/8] / [MASTER_NUM] / [MASTER_NUM]  write data per master
- m_bresp/m_bvalid/m_bready  out/out/in  [MASTER_NUM][2] / [MASTER_NUM] / [MASTER_NUM]  write response per master
- m_araddr/m_arvalid/m_arready  in/in/out  [MASTER_NUM][ADDR_WIDTH] / [MASTER_NUM] / [MASTER_NUM]  read address per master
- m_rdata/m_rresp/m_rvalid/m_rready  out/out/out/in  [MASTER_NUM][DATA_WIDTH] / [MASTER_NUM][2] / [MASTER_NUM] / [MASTER_NUM]  read data per master
- s_* (awaddr, awvalid, awready, wdata, wstrb, wvalid, wready, bresp, bvalid, bready, araddr, arvalid, arready, rdata, rresp, rvalid, rready)  mirrored directions, single-port widths  shared downstream port to the interconnect
- grant_idx  out  $clog2(MASTER_NUM)  currently granted master
- busy  out  1  high whenever state ≠ IDLE

## Operation
- States:
  - IDLE
  - WR_REQ: AW and W outstanding
  - WR_RESP: waiting for B
  - RD_REQ: AR outstanding
  - RD_RESP: waiting for R
- Request from master i: m_awvalid[i] OR m_arvalid[i].
- IDLE:
  - Pick the first requester at or after priority pointer `ptr`, wrapping modulo MASTER_NUM; register it into grant_idx.
  - If that master has awvalid, go to WR_REQ. Otherwise go to RD_REQ. Write wins when one master asserts both.
  - A master asserting only m_wvalid is not a request.
- WR_REQ:
  - Route granted AW and W to s_*; route s_awready/s_wready back to that master.
  - Flags aw_done/w_done set on their handshakes, in either order or the same cycle.
  - Once a channel is done, drive s_awvalid or s_wvalid low respectively.
  - Go to WR_RESP when both are done (including same-cycle completion).
- WR_RESP: route B both ways; on s_bvalid & m_bready[grant] go to IDLE, set ptr = grant+1 mod MASTER_NUM, clear flags.
- RD_REQ: route AR both ways; go to RD_RESP on handshake.
- RD_RESP: route R; on s_rvalid & m_rready[grant] go to IDLE and update ptr as above.
- Non-granted masters see all readies and valids at 0 and their response buses at 0.
- BRESP/RRESP pass through unchanged; SLVERR/DECERR do not change arbitration.
- Reset values:
  - state IDLE, ptr 0, grant_idx 0, busy 0, flags 0.
  - Every m_*ready/m_*valid and every s_*valid/s_*ready output is 0. Data outputs are 0.

## Timing
- Arbitration costs 1 cycle: a request seen in IDLE at edge N is forwarded to s_* from cycle N+1. All routing is combinational from the registered grant and state.
- After the response handshake there is one IDLE bubble cycle; back-to-back transactions cost ≥1 cycle gap.
- Minimum transaction: write 3 cycles (IDLE, WR_REQ, WR_RESP); read 3 cycles.
- Requests arriving while busy are ignored until IDLE; masters must hold valid per AXI rules.
- Reset asserted in any state takes effect at the next edge: state IDLE, all valid/ready outputs 0. The downstream slaves are reset on the same rst.

## Structure
- Add to the shared package axi4_lite_addr_map_package:
  - MASTER_NUM = 2.
  - arb_state_t enum {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP}.
  - AXI response constants RESP_OKAY/RESP_SLVERR/RESP_DECERR.
- Natural sub-module: axi4_lite_rr_picker, a combinational round-robin selector with inputs req vector and ptr, outputs found flag and index.

## Test plan
- M0 write awaddr 0x0000_0100, wdata 0xDEAD_BEEF, wstrb 0xF, slave returns OKAY → s_awaddr/s_wdata match, M0 gets bresp 00, M1 sees m_awready = m_wready = 0 throughout, busy falls after B.
- M0 and M1 both issue reads to 0x0000_1000 immediately after reset → grant order M0 then M1. Repeated simultaneous requests alternate 0,1,0,1. Each rdata is routed only to the granted master.
- M1 presents W 2 cycles before AW → s_wvalid seen first, state stays WR_REQ until the AW handshake, then WR_RESP; no B is accepted before both are done.
- Slave holds s_rvalid low 5 cycles in RD_RESP while M1 requests → grant_idx stays 0 and M1 is untouched until M0's R handshake.
- Assert rst while in RD_RESP → next cycle state IDLE, busy 0, every valid/ready output 0, ptr 0.
- M0 asserts awvalid and arvalid together → write completes first; read is granted in the next arbitration if M0 is still first after the ptr update, otherwise after M1.
